// File: rtl/laser_trip_detector.sv
// Photodiode beam-break detector: calibrates a baseline after arming, then
// flags a latched trip on a debounced intensity drop with hysteresis.
module laser_trip_detector #(
  parameter int DATA_W       = 12,
  parameter int CAL_LOG2     = 4,
  parameter int DROP_MARGIN  = 400,
  parameter int HYST         = 100,
  parameter int DEBOUNCE     = 8,
  parameter int MIN_BASELINE = 600
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic              clear,
  output logic              laser_triggered,
  output logic              calibrated,
  output logic              beam_fault,
  output logic [DATA_W-1:0] baseline
);

  localparam int ACC_W = DATA_W + CAL_LOG2;
  localparam int EXT_W = DATA_W + 1;
  localparam logic [EXT_W-1:0]    DROP_EXT = EXT_W'(DROP_MARGIN);
  localparam logic [EXT_W-1:0]    HYST_EXT = EXT_W'(HYST);
  localparam logic [DATA_W-1:0]   MIN_BASE = DATA_W'(MIN_BASELINE);
  localparam logic [7:0]          DEB      = 8'(DEBOUNCE);
  localparam logic [CAL_LOG2-1:0] CAL_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALIBRATE,
    S_MONITOR,
    S_TRIPPED,
    S_FAULT
  } state_t;

  state_t              state_reg, state_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [CAL_LOG2-1:0] cal_cnt_reg, cal_cnt_next;
  logic [7:0]          dark_reg, dark_next;
  logic [DATA_W-1:0]   baseline_reg, baseline_next;
  logic                trig_reg, trig_next;
  logic                cal_reg, cal_next;
  logic                fault_reg, fault_next;

  logic [EXT_W-1:0]    base_ext, hi_ext;
  logic [DATA_W-1:0]   thr_lo, thr_hi;
  logic [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]   cal_mean;

  // Thresholds are computed one bit wider so both saturations are exact.
  always_comb begin
    base_ext = {1'b0, baseline_reg};
    thr_lo   = (base_ext < DROP_EXT) ? '0 : DATA_W'(base_ext - DROP_EXT);
    hi_ext   = {1'b0, thr_lo} + HYST_EXT;
    thr_hi   = hi_ext[DATA_W] ? '1 : hi_ext[DATA_W-1:0];
    acc_sum  = acc_reg + ACC_W'(sample_data);
    cal_mean = DATA_W'(acc_sum >> CAL_LOG2);
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cal_cnt_next  = cal_cnt_reg;
    dark_next     = dark_reg;
    baseline_next = baseline_reg;

    if (!arm) begin
      state_next   = S_IDLE;
      acc_next     = '0;
      cal_cnt_next = '0;
      dark_next    = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next   = S_CALIBRATE;
          acc_next     = '0;
          cal_cnt_next = '0;
        end
        S_CALIBRATE: begin
          if (sample_valid) begin
            acc_next     = acc_sum;
            cal_cnt_next = cal_cnt_reg + 1'b1;
            if (cal_cnt_reg == CAL_LAST) begin
              baseline_next = cal_mean;
              dark_next     = '0;
              state_next    = (cal_mean < MIN_BASE) ? S_FAULT : S_MONITOR;
            end
          end
        end
        S_MONITOR: begin
          if (sample_valid) begin
            // Samples inside [thr_lo, thr_hi) leave the count untouched.
            if (sample_data < thr_lo) begin
              if (dark_reg < DEB) begin
                dark_next = dark_reg + 8'd1;
              end
              if (dark_next == DEB) begin
                state_next = S_TRIPPED;
              end
            end else if (sample_data >= thr_hi) begin
              dark_next = '0;
            end
          end
        end
        S_TRIPPED: begin
          if (clear) begin
            state_next = S_MONITOR;
            dark_next  = '0;
          end
        end
        S_FAULT: begin
          state_next = S_FAULT;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    trig_next  = (state_next == S_TRIPPED);
    cal_next   = (state_next == S_MONITOR) || (state_next == S_TRIPPED);
    fault_next = (state_next == S_FAULT);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      acc_reg      <= '0;
      cal_cnt_reg  <= '0;
      dark_reg     <= '0;
      baseline_reg <= '0;
      trig_reg     <= 1'b0;
      cal_reg      <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cal_cnt_reg  <= cal_cnt_next;
      dark_reg     <= dark_next;
      baseline_reg <= baseline_next;
      trig_reg     <= trig_next;
      cal_reg      <= cal_next;
      fault_reg    <= fault_next;
    end
  end

  assign laser_triggered = trig_reg;
  assign calibrated      = cal_reg;
  assign beam_fault      = fault_reg;
  assign baseline        = baseline_reg;

endmodule

// File: tb/tb_laser_trip_detector.sv
// Directed bench for laser_trip_detector: expected outputs are queued as each
// cycle is driven and compared one edge later.
module tb_laser_trip_detector;

  logic        clock = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        arm;
  logic        clear;
  logic        laser_triggered;
  logic        calibrated;
  logic        beam_fault;
  logic [11:0] baseline;

  laser_trip_detector dut (
    .clock           (clock),
    .rst             (rst),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .arm             (arm),
    .clear           (clear),
    .laser_triggered (laser_triggered),
    .calibrated      (calibrated),
    .beam_fault      (beam_fault),
    .baseline        (baseline)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        trig;
    logic        cal;
    logic        fault;
    logic [11:0] base;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  string       phase = "reset";
  logic        e_trig, e_cal, e_fault;
  logic [11:0] e_base;

  task automatic push_exp();
    exp_t e;
    e.trig  = e_trig;
    e.cal   = e_cal;
    e.fault = e_fault;
    e.base  = e_base;
    e.tag   = phase;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (laser_triggered === e.trig) else begin
      errors++;
      $error("FAIL %s laser_triggered observed=%0b expected=%0b", e.tag, laser_triggered, e.trig);
    end
    checks++;
    assert (calibrated === e.cal) else begin
      errors++;
      $error("FAIL %s calibrated observed=%0b expected=%0b", e.tag, calibrated, e.cal);
    end
    checks++;
    assert (beam_fault === e.fault) else begin
      errors++;
      $error("FAIL %s beam_fault observed=%0b expected=%0b", e.tag, beam_fault, e.fault);
    end
    checks++;
    assert (baseline === e.base) else begin
      errors++;
      $error("FAIL %s baseline observed=%0d expected=%0d", e.tag, baseline, e.base);
    end
  endtask

  // One clock cycle: drive, queue expectation for after the edge, compare.
  task automatic tick(input logic v, input logic [11:0] d);
    sample_valid = v;
    sample_data  = d;
    push_exp();
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
    pop_check();
  endtask

  task automatic feed(input int n, input logic [11:0] d);
    for (int i = 0; i < n; i++) tick(1'b1, d);
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0; clear = 1'b0;
    sample_valid = 1'b0; sample_data = '0;
    e_trig = 1'b0; e_cal = 1'b0; e_fault = 1'b0; e_base = '0;

    #2;
    push_exp();
    pop_check();
    tick(1'b0, 12'd0);
    tick(1'b0, 12'd0);
    rst = 1'b1;
    tick(1'b0, 12'd0);
    tick(1'b1, 12'd2000);

    // Arm cycle's sample must not be accumulated.
    phase = "calibrate";
    arm = 1'b1;
    tick(1'b1, 12'd4000);
    feed(15, 12'd2000);
    e_cal = 1'b1; e_base = 12'd2000;
    tick(1'b1, 12'd2000);

    phase = "trip8";
    feed(7, 12'd1500);
    e_trig = 1'b1;
    tick(1'b1, 12'd1500);
    feed(3, 12'd1500);

    phase = "clear";
    clear = 1'b1; e_trig = 1'b0;
    tick(1'b1, 12'd1500);
    feed(7, 12'd1500);
    e_trig = 1'b1;
    tick(1'b1, 12'd1500);

    phase = "hyst_hold";
    clear = 1'b1; e_trig = 1'b0;
    tick(1'b0, 12'd0);
    feed(5, 12'd1500);
    feed(3, 12'd1650);
    feed(2, 12'd1500);
    e_trig = 1'b1;
    tick(1'b1, 12'd1500);

    phase = "hyst_reset";
    clear = 1'b1; e_trig = 1'b0;
    tick(1'b0, 12'd0);
    feed(5, 12'd1500);
    feed(3, 12'd1800);
    feed(3, 12'd1500);
    feed(1, 12'd1700);
    feed(7, 12'd1500);
    feed(1, 12'd1600);
    e_trig = 1'b1;
    tick(1'b1, 12'd1599);

    phase = "clear_and_arm_drop";
    clear = 1'b1; arm = 1'b0;
    e_trig = 1'b0; e_cal = 1'b0;
    tick(1'b0, 12'd0);
    feed(3, 12'd1500);

    phase = "fault";
    arm = 1'b1;
    tick(1'b0, 12'd0);
    feed(15, 12'd500);
    e_fault = 1'b1; e_base = 12'd500;
    tick(1'b1, 12'd500);
    feed(100, 12'd0);
    clear = 1'b1;
    tick(1'b1, 12'd0);
    arm = 1'b0; e_fault = 1'b0;
    tick(1'b0, 12'd0);

    phase = "mid_cal_drop";
    arm = 1'b1;
    tick(1'b0, 12'd0);
    feed(10, 12'd3000);
    arm = 1'b0;
    tick(1'b1, 12'd3000);
    tick(1'b0, 12'd0);
    arm = 1'b1;
    tick(1'b0, 12'd0);
    feed(15, 12'd1000);
    e_cal = 1'b1; e_base = 12'd1000;
    tick(1'b1, 12'd1000);

    phase = "trip_base1000";
    feed(7, 12'd599);
    e_trig = 1'b1;
    tick(1'b1, 12'd599);

    // Reset must clear outputs between clock edges.
    phase = "async_reset";
    @(negedge clock);
    e_trig = 1'b0; e_cal = 1'b0; e_fault = 1'b0; e_base = '0;
    push_exp();
    rst = 1'b0;
    arm = 1'b0;
    #1;
    pop_check();
    @(posedge clock);
    #1;
    rst = 1'b1;
    tick(1'b0, 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
